bean_hit_ctrl: RTL and testbench

- Consumer end of the obstacle generator's `bean`/`check_hit` interface.
- Receives the obstacle pixel mask and the goose pixel mask for every drawn pixel, and detects overlap per frame.
- Runs the game-state FSM: it drives `check_hit` back to the generator to freeze scrolling, pulses `game_reset` to restart all movers, and keeps the run score.
- Sits between the VGA pixel pipeline and the draw/mover blocks.

---
 rtl/bean_hit_ctrl.sv | 149 ++++++++++++++
 tb/tb_bean_hit_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bean_hit_ctrl.sv
// Game-state controller: per-frame goose/bean overlap detection, run scoring.
// Optional best-score register enabled by defining BEAN_HISCORE_EN.
module bean_hit_ctrl #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int HIT_MIN_PIX = 4,
    parameter int SCORE_DIV   = 6,
    parameter int GO_DELAY    = 30,
    parameter int SCORE_W     = 14
) (
    input  logic               clk_pix,
    input  logic               reset_n,
    input  logic               pix_en,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               bean,
    input  logic               goose,
    input  logic [1:0]         button,
    output logic               check_hit,
    output logic               game_reset,
    output logic               game_over,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score
);

    localparam int FC_MAX = (SCORE_DIV > GO_DELAY) ? SCORE_DIV : GO_DELAY;
    localparam int FC_W   = $clog2(FC_MAX + 1);
    localparam int OV_W   = $clog2(HIT_MIN_PIX + 1);

    localparam logic [9:0]      X_LAST   = 10'(H_ACTIVE - 1);
    localparam logic [9:0]      Y_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [OV_W-1:0] OV_SAT   = OV_W'(HIT_MIN_PIX);
    localparam logic [FC_W-1:0] FC_SCORE = FC_W'(SCORE_DIV - 1);
    localparam logic [FC_W-1:0] FC_GO    = FC_W'(GO_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t          cur;
    state_t          nxt;
    logic            btn_q;
    logic            btn_qq;
    logic            press;
    logic            vis;
    logic            frame_end;
    logic            ovl_pix;
    logic            hit_now;
    logic [OV_W-1:0] ovl_cnt;
    logic [OV_W-1:0] ovl_inc;
    logic [FC_W-1:0] fcnt;

    assign press     = btn_q & ~btn_qq;
    assign vis       = pix_en && (x <= X_LAST) && (y <= Y_LAST);
    assign frame_end = pix_en && (x == X_LAST) && (y == Y_LAST);
    assign ovl_pix   = vis && bean && goose && (cur == RUN);
    assign state     = cur;

    // The frame_end pixel itself still contributes to that frame's count.
    always_comb begin
        ovl_inc = ovl_cnt;
        if (ovl_pix && ovl_cnt != OV_SAT) begin
            ovl_inc = ovl_cnt + 1'b1;
        end
    end

    assign hit_now = frame_end && (ovl_inc >= OV_SAT);

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE:    if (press) nxt = RUN;
            RUN:     if (hit_now) nxt = HIT;
            HIT:     if (frame_end && fcnt == FC_GO) nxt = OVER;
            OVER:    if (press) nxt = RUN;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (!reset_n) begin
            cur        <= IDLE;
            btn_q      <= 1'b0;
            btn_qq     <= 1'b0;
            check_hit  <= 1'b0;
            game_over  <= 1'b0;
            game_reset <= 1'b0;
            ovl_cnt    <= '0;
            fcnt       <= '0;
            score      <= '0;
        end else begin
            btn_q      <= |button;
            btn_qq     <= btn_q;
            cur        <= nxt;
            check_hit  <= (nxt == HIT) || (nxt == OVER);
            game_over  <= (nxt == OVER);
            game_reset <= ((cur == IDLE) || (cur == OVER)) && press;

            if (nxt != cur || frame_end) begin
                ovl_cnt <= '0;
            end else begin
                ovl_cnt <= ovl_inc;
            end

            unique case (cur)
                IDLE, OVER: begin
                    if (press) begin
                        score <= '0;
                        fcnt  <= '0;
                    end
                end
                RUN: begin
                    if (frame_end) begin
                        if (fcnt == FC_SCORE) begin
                            fcnt <= '0;
                            if (score != '1) score <= score + 1'b1;
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                        if (hit_now) fcnt <= '0;
                    end
                end
                HIT: begin
                    if (frame_end) begin
                        fcnt <= (nxt == OVER) ? '0 : fcnt + 1'b1;
                    end
                end
                default: fcnt <= '0;
            endcase
        end
    end

`ifdef BEAN_HISCORE_EN
    always_ff @(posedge clk_pix) begin
        if (!reset_n) begin
            hi_score <= '0;
        end else if (cur == HIT && nxt == OVER && score > hi_score) begin
            hi_score <= score;
        end
    end
`else
    assign hi_score = '0;
`endif

endmodule

// File: tb/tb_bean_hit_ctrl.sv
// Self-checking bench for bean_hit_ctrl: frame-level reference model plus
// directed scenarios (start, scoring, hit threshold, game over, restart, reset).
module tb_bean_hit_ctrl;

    localparam int SCORE_DIV = 6;
    localparam int GO_DELAY  = 30;
    localparam int HIT_MIN   = 4;
    localparam int SMAX      = (1 << 14) - 1;

    logic        clk_pix;
    logic        reset_n;
    logic        pix_en;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        bean;
    logic        goose;
    logic [1:0]  button;
    logic        check_hit;
    logic        game_reset;
    logic        game_over;
    logic [1:0]  state;
    logic [13:0] score;
    logic [13:0] hi_score;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    bean_hit_ctrl dut (
        .clk_pix    (clk_pix),
        .reset_n    (reset_n),
        .pix_en     (pix_en),
        .x          (x),
        .y          (y),
        .bean       (bean),
        .goose      (goose),
        .button     (button),
        .check_hit  (check_hit),
        .game_reset (game_reset),
        .game_over  (game_over),
        .state      (state),
        .score      (score),
        .hi_score   (hi_score)
    );

    initial clk_pix = 0;
    always #5 clk_pix = ~clk_pix;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: frames since run start, overlap pixels this frame,
    // frames since the hit; score is derived from frames run.
    int m_state, m_pix, m_runf, m_hitf, m_score, m_hi;
    bit m_gr, b1, b2;

    always @(posedge clk_pix) begin
        bit pr, fe, ov;
        if (!reset_n) begin
            m_state = 0; m_pix = 0; m_runf = 0; m_hitf = 0;
            m_score = 0; m_hi = 0; m_gr = 0; b1 = 0; b2 = 0;
        end else begin
            pr = b1 && !b2;
            b2 = b1;
            b1 = |button;
            fe = pix_en && x == 639 && y == 479;
            ov = pix_en && x < 640 && y < 480 && bean && goose;
            m_gr = 0;
            case (m_state)
                0, 3: if (pr) begin
                    m_state = 1; m_runf = 0; m_score = 0;
                    m_pix = 0; m_gr = 1;
                end
                1: begin
                    if (ov) m_pix++;
                    if (fe) begin
                        m_runf++;
                        m_score = m_runf / SCORE_DIV;
                        if (m_score > SMAX) m_score = SMAX;
                        if (m_pix >= HIT_MIN) begin
                            m_state = 2; m_hitf = 0;
                        end
                        m_pix = 0;
                    end
                end
                default: if (fe) begin
                    m_hitf++;
                    if (m_hitf == GO_DELAY) begin
                        m_state = 3;
`ifdef BEAN_HISCORE_EN
                        if (m_score > m_hi) m_hi = m_score;
`endif
                    end
                end
            endcase
        end
    end

    always @(negedge clk_pix) begin
        if (chk_en) begin
            check("state", state, m_state);
            check("check_hit", check_hit, m_state >= 2);
            check("game_over", game_over, m_state == 3);
            check("game_reset", game_reset, m_gr);
            check("score", score, m_score);
            check("hi_score", hi_score, m_hi);
        end
    end

    task automatic drive(input logic en, input int xx, input int yy,
                         input logic b, input logic g);
        pix_en = en;
        x      = 10'(xx);
        y      = 10'(yy);
        bean   = b;
        goose  = g;
        @(negedge clk_pix);
    endtask

    // nov overlapping pixels starting at column ox, then a masked pixel
    // with pix_en low, then the frame_end pixel.
    task automatic frame(input int nov, input int ox);
        for (int i = 0; i < nov; i++) drive(1, ox + i, 100, 1, 1);
        drive(0, 50, 50, 1, 1);
        drive(1, 639, 479, 0, 0);
    endtask

    task automatic press_count(input logic [1:0] b, input int n,
                               output int cnt, output int at);
        cnt = 0;
        at  = -1;
        button = b;
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0);
            if (game_reset === 1'b1) begin
                cnt++;
                at = i;
            end
        end
        button = 2'b00;
        drive(0, 0, 0, 0, 0);
    endtask

    int cnt, at, exp_hi;

    initial begin
        reset_n = 0;
        button  = 2'b00;
        pix_en  = 0; x = 0; y = 0; bean = 0; goose = 0;
`ifdef BEAN_HISCORE_EN
        exp_hi = 10;
`else
        exp_hi = 0;
`endif
        @(negedge clk_pix);
        chk_en = 1;
        drive(0, 0, 0, 0, 0);
        check("rst_state", state, 0);
        check("rst_score", score, 0);
        reset_n = 1;
        drive(0, 0, 0, 0, 0);

        press_count(2'b01, 10, cnt, at);
        check("start_pulses", cnt, 1);
        check("start_pulse_at", at, 1);
        check("start_state", state, 1);
        check("start_score", score, 0);

        for (int f = 0; f < 60; f++) frame((f % 7 == 3) ? 4 : 0, 700);
        check("score60", score, 10);
        check("ch60", check_hit, 0);

        frame(3, 10);
        check("ovl3_state", state, 1);
        frame(4, 10);
        check("ovl4_state", state, 2);
        check("ovl4_ch", check_hit, 1);
        check("hit_score", score, 10);

        press_count(2'b01, 4, cnt, at);
        check("hit_press_pulses", cnt, 0);
        check("hit_press_state", state, 2);

        for (int f = 0; f < 29; f++) frame(0, 0);
        check("hit29_state", state, 2);
        frame(0, 0);
        check("over_state", state, 3);
        check("over_go", game_over, 1);
        check("over_hi", hi_score, exp_hi);

        press_count(2'b10, 4, cnt, at);
        check("re_pulses", cnt, 1);
        check("re_state", state, 1);
        check("re_ch", check_hit, 0);
        check("re_score", score, 0);

        for (int f = 0; f < 29; f++) frame(0, 0);
        frame(4, 200);
        check("run2_state", state, 2);
        check("run2_score", score, 5);
        for (int f = 0; f < 30; f++) frame(0, 0);
        check("run2_over", state, 3);
        check("run2_hi", hi_score, exp_hi);

        press_count(2'b01, 4, cnt, at);
        frame(5, 300);
        check("run3_hit", state, 2);
        reset_n = 0;
        drive(0, 0, 0, 0, 0);
        check("mid_rst_state", state, 0);
        check("mid_rst_outs", {check_hit, game_over, game_reset}, 0);
        check("mid_rst_score", score, 0);
        check("mid_rst_hi", hi_score, 0);
        reset_n = 1;
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
